// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants, register-address type and hazard FSM state type.
package riscv_pipe_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned SB_DEPTH     = 3;
    // A taken jump squashes its own cycle plus one FLUSH cycle.
    localparam int unsigned FLUSH_CYCLES = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } hz_state_e;

    // A source only conflicts with an in-flight write when it names a real register (not x0).
    function automatic logic reg_match(input reg_addr_t src, input reg_addr_t dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Decode-stage request signals and hazard-unit control responses.
interface hazard_control_if;
    import riscv_pipe_pkg::*;

    reg_addr_t   a0;
    reg_addr_t   a1;
    reg_addr_t   a2_hazard;
    logic        jmp_taken;
    logic        mem_wait;
    logic        stall;
    logic        squash;
    logic        fetch_hold;
    logic [15:0] stall_count;

    // Pipeline side: presents decode operands and execute/memory status.
    modport master (
        output a0, a1, a2_hazard, jmp_taken, mem_wait,
        input  stall, squash, fetch_hold, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  a0, a1, a2_hazard, jmp_taken, mem_wait,
        output stall, squash, fetch_hold, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination register slots (ex, mem, wb) and RAW comparators.
module hazard_scoreboard
    import riscv_pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      advance,
    input  reg_addr_t dst_in,
    input  reg_addr_t src0,
    input  reg_addr_t src1,
    output logic      raw
);

    reg_addr_t sb_q [SB_DEPTH];

    // Shift the slots toward writeback on every non-stalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                sb_q[i] <= '0;
            end
        end else if (advance) begin
            sb_q[0] <= dst_in;
            for (int i = 1; i < int'(SB_DEPTH); i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    // Any source register matching any in-flight destination is a RAW hazard.
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            raw = raw | reg_match(src0, sb_q[i]) | reg_match(src1, sb_q[i]);
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard control: memory freeze, jump flush and RAW interlock with hold counter.
module hazard_control
    import riscv_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    hazard_control_if.slave  hz
);

    hz_state_e   state_q;
    logic [15:0] count_q;
    logic        raw;
    logic        advance;
    reg_addr_t   dst_in;

    assign advance = ~hz.mem_wait;
    // A squashed decode instruction never reaches execute, so it claims no register.
    assign dst_in  = hz.squash ? '0 : hz.a2_hazard;

    hazard_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .dst_in  (dst_in),
        .src0    (hz.a0),
        .src1    (hz.a1),
        .raw     (raw)
    );

    // Same-cycle control outputs; priority is reset, mem_wait, jump/flush, then raw.
    always_comb begin
        hz.stall      = 1'b0;
        hz.squash     = 1'b0;
        hz.fetch_hold = 1'b0;
        if (rst) begin
            hz.squash = 1'b1;
        end else if (hz.mem_wait) begin
            hz.stall = 1'b1;
        end else if (hz.jmp_taken || (state_q == StFlush)) begin
            hz.squash = 1'b1;
        end else if (raw) begin
            hz.squash     = 1'b1;
            hz.fetch_hold = 1'b1;
        end
    end

    assign hz.stall_count = count_q;

    // FSM and saturating hold counter; both freeze while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            count_q <= '0;
        end else if (!hz.mem_wait) begin
            state_q <= hz.jmp_taken ? StFlush : StRun;
            if (hz.fetch_hold && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_hazard_control;
    import riscv_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_control_if hz_if ();

    hazard_control dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: list of in-flight destinations (newest first), flush flag, hold total.
    logic [4:0]  model_sb [$] = '{5'd0, 5'd0, 5'd0};
    bit          model_flush = 1'b0;
    int unsigned model_count = 0;
    bit          exp_stall, exp_squash, exp_hold;

    logic        obs_stall, obs_squash, obs_hold;
    logic [15:0] obs_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_raw();
        bit hit = 1'b0;
        foreach (model_sb[i]) begin
            if (hz_if.a0 != 0 && hz_if.a0 == model_sb[i]) hit = 1'b1;
            if (hz_if.a1 != 0 && hz_if.a1 == model_sb[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic model_comb();
        exp_stall  = 1'b0;
        exp_squash = 1'b0;
        exp_hold   = 1'b0;
        if (rst) begin
            exp_squash = 1'b1;
        end else if (hz_if.mem_wait) begin
            exp_stall = 1'b1;
        end else if (hz_if.jmp_taken || model_flush) begin
            exp_squash = 1'b1;
        end else if (model_raw()) begin
            exp_squash = 1'b1;
            exp_hold   = 1'b1;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_sb    = '{5'd0, 5'd0, 5'd0};
            model_flush = 1'b0;
            model_count = 0;
        end else if (!hz_if.mem_wait) begin
            model_sb.push_front(exp_squash ? 5'd0 : hz_if.a2_hazard);
            void'(model_sb.pop_back());
            model_flush = hz_if.jmp_taken;
            if (exp_hold && model_count < 65535) model_count++;
        end
    endtask

    task automatic drive(input bit r, input logic [4:0] x0, input logic [4:0] x1,
                         input logic [4:0] x2, input bit j, input bit m);
        rst                = r;
        hz_if.a0           = x0;
        hz_if.a1           = x1;
        hz_if.a2_hazard    = x2;
        hz_if.jmp_taken    = j;
        hz_if.mem_wait     = m;
    endtask

    // One clock: sample mid-cycle, optionally compare with the model, then advance the model.
    task automatic cycle(input bit do_check);
        @(negedge clk);
        model_comb();
        obs_stall  = hz_if.stall;
        obs_squash = hz_if.squash;
        obs_hold   = hz_if.fetch_hold;
        obs_count  = hz_if.stall_count;
        if (do_check) begin
            check_eq("stall", 32'(obs_stall), 32'(exp_stall));
            check_eq("squash", 32'(obs_squash), 32'(exp_squash));
            check_eq("fetch_hold", 32'(obs_hold), 32'(exp_hold));
            check_eq("stall_count", 32'(obs_count), model_count);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        // Reset with every other input asserted.
        drive(1, 5'd3, 5'd4, 5'd5, 1, 1);
        cycle(1);
        check_eq("rst_squash", 32'(obs_squash), 32'd1);
        check_eq("rst_stall", 32'(obs_stall), 32'd0);
        check_eq("rst_hold", 32'(obs_hold), 32'd0);
        cycle(1);
        check_eq("rst_count", 32'(obs_count), 32'd0);

        // Back-to-back RAW on r5: three hold cycles, then clear.
        drive(0, 5'd0, 5'd0, 5'd5, 0, 0);
        cycle(1);
        for (int c = 1; c <= 3; c++) begin
            drive(0, 5'd5, 5'd0, 5'd0, 0, 0);
            cycle(1);
            check_eq($sformatf("b2b_hold_c%0d", c), 32'(obs_hold), 32'd1);
            check_eq($sformatf("b2b_squash_c%0d", c), 32'(obs_squash), 32'd1);
        end
        cycle(1);
        check_eq("b2b_clear", 32'(obs_hold), 32'd0);
        check_eq("b2b_count", 32'(obs_count), 32'd3);

        // Jump while a RAW is pending: two squash cycles, then raw honoured.
        drive(1, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(1);
        drive(0, 5'd0, 5'd0, 5'd3, 0, 0);
        cycle(1);
        drive(0, 5'd3, 5'd0, 5'd0, 1, 0);
        cycle(1);
        check_eq("jmp_squash", 32'(obs_squash), 32'd1);
        check_eq("jmp_hold", 32'(obs_hold), 32'd0);
        drive(0, 5'd3, 5'd0, 5'd0, 0, 0);
        cycle(1);
        check_eq("flush_squash", 32'(obs_squash), 32'd1);
        check_eq("flush_hold", 32'(obs_hold), 32'd0);
        cycle(1);
        check_eq("post_flush_hold", 32'(obs_hold), 32'd1);
        check_eq("jmp_count", 32'(obs_count), 32'd0);

        // mem_wait freezes a hold on r7, which resumes afterwards.
        drive(1, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(1);
        drive(0, 5'd0, 5'd0, 5'd7, 0, 0);
        cycle(1);
        drive(0, 5'd7, 5'd0, 5'd0, 0, 0);
        cycle(1);
        check_eq("mw_first_hold", 32'(obs_hold), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            drive(0, 5'd7, 5'd0, 5'd0, 0, 1);
            cycle(1);
            check_eq($sformatf("mw_stall_c%0d", c), 32'(obs_stall), 32'd1);
            check_eq($sformatf("mw_squash_c%0d", c), 32'(obs_squash), 32'd0);
        end
        drive(0, 5'd7, 5'd0, 5'd0, 0, 0);
        cycle(1);
        check_eq("mw_resume_c5", 32'(obs_hold), 32'd1);
        cycle(1);
        check_eq("mw_resume_c6", 32'(obs_hold), 32'd1);
        cycle(1);
        check_eq("mw_clear_c7", 32'(obs_hold), 32'd0);
        check_eq("mw_count", 32'(obs_count), 32'd3);

        // x0 never hazards; an instruction never holds on its own destination.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(1);
        cycle(1);
        check_eq("x0_hold", 32'(obs_hold), 32'd0);
        drive(0, 5'd9, 5'd0, 5'd9, 0, 0);
        cycle(1);
        check_eq("self_hold", 32'(obs_hold), 32'd0);

        // Random traffic over a small register range to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 49) == 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
            cycle(1);
        end

        // Saturation: 21847 rounds of one producer plus three held consumers.
        drive(1, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(1);
        for (int n = 0; n < 21847; n++) begin
            drive(0, 5'd0, 5'd0, 5'd5, 0, 0);
            cycle(0);
            drive(0, 5'd5, 5'd0, 5'd0, 0, 0);
            cycle(0);
            cycle(0);
            cycle(0);
        end
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(1);
        check_eq("sat_count", 32'(obs_count), 32'h0000FFFF);
        drive(0, 5'd0, 5'd0, 5'd5, 0, 0);
        cycle(1);
        drive(1, 5'd5, 5'd0, 5'd0, 0, 0);
        cycle(1);
        check_eq("sat_rst_squash", 32'(obs_squash), 32'd1);
        drive(0, 5'd5, 5'd0, 5'd0, 0, 0);
        cycle(1);
        check_eq("post_rst_hold", 32'(obs_hold), 32'd0);
        check_eq("post_rst_count", 32'(obs_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
